// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the PC update unit and a single-outstanding imem read,
// handing 16-bit instructions to decode over valid/ready with branch redirects.
module fetch_sequencer #(
    parameter int          MEM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int         ADDR_WIDTH = $clog2(MEM_DEPTH * 2)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic [1:0]            o_pc_mode,
    output logic [31:0]           o_pc_cur,
    output logic [31:0]           o_branch_offset,
    input  logic [31:0]           i_pc_next,
    input  logic                  i_branch_valid,
    input  logic [31:0]           i_branch_offset,
    output logic                  o_imem_req,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [15:0]           i_imem_rdata,
    output logic                  o_instr_valid,
    output logic [15:0]           o_instr,
    output logic [31:0]           o_instr_pc,
    input  logic                  i_instr_ready
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_VALID, S_DROP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, pc_d, instr_pc_q;
    logic [15:0] instr_q;

    assign o_instr_valid   = state_q == S_VALID && !i_branch_valid;
    assign o_imem_req      = state_q == S_FETCH && !i_reset;
    assign o_pc_mode       = i_reset ? 2'b00 : i_branch_valid ? 2'b10 :
                             (o_instr_valid && i_instr_ready) ? 2'b01 : 2'b00;
    assign pc_d            = o_pc_mode != 2'b00 ? i_pc_next : pc_q;
    assign o_pc_cur        = pc_q;
    assign o_branch_offset = i_branch_offset;
    assign o_imem_addr     = pc_q[ADDR_WIDTH-1:0];
    assign o_instr         = instr_q;
    assign o_instr_pc      = instr_pc_q;

    // The instruction PC is the unchanged PC: the PC only moves on handoff or branch.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                S_FETCH: if (i_imem_gnt) state_q <= i_branch_valid ? S_DROP : S_WAIT;
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        state_q <= i_branch_valid ? S_FETCH : S_VALID;
                        if (!i_branch_valid) begin
                            instr_q    <= i_imem_rdata;
                            instr_pc_q <= pc_q;
                        end
                    end else if (i_branch_valid) begin
                        state_q <= S_DROP;
                    end
                end
                S_VALID: if (i_branch_valid || i_instr_ready) state_q <= S_FETCH;
                S_DROP:  if (i_imem_rvalid) state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: per-cycle directed vectors plus an async-reset sequence.
module tb_fetch_sequencer;
    logic        clk = 0, rst = 1;
    logic        gnt = 0, rv = 0, br = 0, rdy = 0;
    logic [15:0] rdata = 0;
    logic [31:0] off = 0;
    logic [1:0]  mode, mode_w;
    logic [31:0] pc, pc_w, boff, boff_w, pn, pn_w, ipc, ipc_w;
    logic        req, req_w, vld, vld_w;
    logic [12:0] addr, addr_w;
    logic [15:0] instr, instr_w;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    // Reference PC update unit for each instance
    assign pn   = mode == 2'b10 ? pc + boff : pc + 32'd2;
    assign pn_w = mode_w == 2'b10 ? pc_w + boff_w : pc_w + 32'd2;

    fetch_sequencer dut (
        .i_clk(clk), .i_reset(rst), .o_pc_mode(mode), .o_pc_cur(pc), .o_branch_offset(boff),
        .i_pc_next(pn), .i_branch_valid(br), .i_branch_offset(off), .o_imem_req(req),
        .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rv), .i_imem_rdata(rdata),
        .o_instr_valid(vld), .o_instr(instr), .o_instr_pc(ipc), .i_instr_ready(rdy));

    fetch_sequencer #(.RESET_PC(32'h0000_1FFE)) dut_w (
        .i_clk(clk), .i_reset(rst), .o_pc_mode(mode_w), .o_pc_cur(pc_w), .o_branch_offset(boff_w),
        .i_pc_next(pn_w), .i_branch_valid(br), .i_branch_offset(off), .o_imem_req(req_w),
        .o_imem_addr(addr_w), .i_imem_gnt(gnt), .i_imem_rvalid(rv), .i_imem_rdata(rdata),
        .o_instr_valid(vld_w), .o_instr(instr_w), .o_instr_pc(ipc_w), .i_instr_ready(rdy));

    typedef struct {
        logic        gnt, rv;
        logic [15:0] rdata;
        logic        br;
        logic [31:0] off;
        logic        rdy, req;
        logic [12:0] addr;
        logic [1:0]  mode;
        logic        vld;
        logic [15:0] instr;
        logic [31:0] ipc;
    } vec_t;

    vec_t tv[37];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        //          gnt rv rdata     br off           rdy req addr      mode  vld instr     ipc
        tv[0]  = '{1, 0, 16'h0,    0, 32'h0,        0, 1, 13'h0,   2'b00, 0, 16'h0,    32'h0};
        tv[1]  = '{0, 1, 16'hA000, 0, 32'h0,        0, 0, 13'h0,   2'b00, 0, 16'h0,    32'h0};
        tv[2]  = '{0, 0, 16'h0,    0, 32'h0,        1, 0, 13'h0,   2'b01, 1, 16'hA000, 32'h0};
        tv[3]  = '{1, 0, 16'h0,    0, 32'h0,        1, 1, 13'h2,   2'b00, 0, 16'h0,    32'h0};
        tv[4]  = '{0, 1, 16'hA002, 0, 32'h0,        1, 0, 13'h2,   2'b00, 0, 16'h0,    32'h0};
        tv[5]  = '{0, 0, 16'h0,    0, 32'h0,        1, 0, 13'h2,   2'b01, 1, 16'hA002, 32'h2};
        tv[6]  = '{1, 0, 16'h0,    0, 32'h0,        1, 1, 13'h4,   2'b00, 0, 16'h0,    32'h2};
        tv[7]  = '{0, 1, 16'hA004, 0, 32'h0,        1, 0, 13'h4,   2'b00, 0, 16'h0,    32'h2};
        tv[8]  = '{0, 0, 16'h0,    0, 32'h0,        1, 0, 13'h4,   2'b01, 1, 16'hA004, 32'h4};
        tv[9]  = '{0, 0, 16'h0,    1, 32'hA,        0, 1, 13'h6,   2'b10, 0, 16'h0,    32'h4};
        tv[10] = '{1, 0, 16'h0,    0, 32'h0,        0, 1, 13'h10,  2'b00, 0, 16'h0,    32'h4};
        tv[11] = '{0, 1, 16'hB010, 0, 32'h0,        0, 0, 13'h10,  2'b00, 0, 16'h0,    32'h4};
        for (int i = 12; i < 17; i++)
            tv[i] = '{0, 0, 16'h0, 0, 32'h0,        0, 0, 13'h10,  2'b00, 1, 16'hB010, 32'h10};
        tv[17] = '{0, 0, 16'h0,    0, 32'h0,        1, 0, 13'h10,  2'b01, 1, 16'hB010, 32'h10};
        tv[18] = '{1, 0, 16'h0,    1, 32'hE,        0, 1, 13'h12,  2'b10, 0, 16'h0,    32'h10};
        tv[19] = '{0, 0, 16'h0,    0, 32'h0,        0, 0, 13'h20,  2'b00, 0, 16'h0,    32'h10};
        tv[20] = '{0, 1, 16'hDEAD, 0, 32'h0,        0, 0, 13'h20,  2'b00, 0, 16'h0,    32'h10};
        tv[21] = '{1, 0, 16'h0,    0, 32'h0,        0, 1, 13'h20,  2'b00, 0, 16'h0,    32'h10};
        tv[22] = '{0, 0, 16'h0,    1, 32'h30,       0, 0, 13'h20,  2'b10, 0, 16'h0,    32'h10};
        tv[23] = '{0, 0, 16'h0,    1, 32'h10,       0, 0, 13'h50,  2'b10, 0, 16'h0,    32'h10};
        tv[24] = '{0, 1, 16'hDEAD, 0, 32'h0,        0, 0, 13'h60,  2'b00, 0, 16'h0,    32'h10};
        tv[25] = '{1, 0, 16'h0,    0, 32'h0,        0, 1, 13'h60,  2'b00, 0, 16'h0,    32'h10};
        tv[26] = '{0, 1, 16'hC060, 0, 32'h0,        0, 0, 13'h60,  2'b00, 0, 16'h0,    32'h10};
        tv[27] = '{0, 0, 16'h0,    0, 32'h0,        1, 0, 13'h60,  2'b01, 1, 16'hC060, 32'h60};
        tv[28] = '{0, 0, 16'h0,    1, 32'h9E,       0, 1, 13'h62,  2'b10, 0, 16'h0,    32'h60};
        tv[29] = '{1, 0, 16'h0,    0, 32'h0,        0, 1, 13'h100, 2'b00, 0, 16'h0,    32'h60};
        tv[30] = '{0, 1, 16'hD100, 0, 32'h0,        0, 0, 13'h100, 2'b00, 0, 16'h0,    32'h60};
        tv[31] = '{0, 0, 16'h0,    1, 32'hFFFF_FFF8, 1, 0, 13'h100, 2'b10, 0, 16'h0,   32'h100};
        tv[32] = '{1, 0, 16'h0,    0, 32'h0,        0, 1, 13'hF8,  2'b00, 0, 16'h0,    32'h100};
        tv[33] = '{0, 1, 16'hBAD0, 1, 32'h4,        0, 0, 13'hF8,  2'b10, 0, 16'h0,    32'h100};
        tv[34] = '{0, 0, 16'h0,    0, 32'h0,        0, 1, 13'hFC,  2'b00, 0, 16'h0,    32'h100};
        tv[35] = '{1, 0, 16'h0,    0, 32'h0,        0, 1, 13'hFC,  2'b00, 0, 16'h0,    32'h100};
        tv[36] = '{0, 0, 16'h0,    0, 32'h0,        0, 0, 13'hFC,  2'b00, 0, 16'h0,    32'h100};

        repeat (2) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_mode", mode, 0);
        chk("rst_vld", vld, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ipc", ipc, 0);
        chk("rst_pc", pc, 0);
        chk("rst_pc_w", pc_w, 32'h1FFE);
        rst = 0;
        for (int i = 0; i < 37; i++) begin
            gnt = tv[i].gnt; rv = tv[i].rv; rdata = tv[i].rdata;
            br = tv[i].br; off = tv[i].off; rdy = tv[i].rdy;
            #1;
            chk($sformatf("v%0d_req", i), req, tv[i].req);
            chk($sformatf("v%0d_addr", i), addr, tv[i].addr);
            chk($sformatf("v%0d_mode", i), mode, tv[i].mode);
            chk($sformatf("v%0d_vld", i), vld, tv[i].vld);
            chk($sformatf("v%0d_ipc", i), ipc, tv[i].ipc);
            chk($sformatf("v%0d_waddr", i), addr_w, 32'((tv[i].addr - 13'd2) & 13'h1FFF));
            if (tv[i].vld) chk($sformatf("v%0d_instr", i), instr, tv[i].instr);
            @(negedge clk);
        end
        // Async reset while WAIT is outstanding, with late responses around release
        gnt = 0; rv = 0; br = 0; rdy = 0;
        #2 rst = 1;
        #1;
        chk("arst_req", req, 0);
        chk("arst_ipc", ipc, 0);
        chk("arst_instr", instr, 0);
        chk("arst_pc", pc, 0);
        rv = 1; rdata = 16'hEEEE;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rel_req", req, 1);
        chk("rel_addr", addr, 0);
        chk("rel_vld", vld, 0);
        @(negedge clk);
        rv = 0; gnt = 1;
        #1;
        chk("rel2_req", req, 1);
        chk("rel2_addr", addr, 0);
        chk("rel2_vld", vld, 0);
        @(negedge clk);
        gnt = 0; rv = 1; rdata = 16'hF000;
        #1;
        chk("rel3_vld", vld, 0);
        chk("rel3_req", req, 0);
        @(negedge clk);
        rv = 0; rdy = 1;
        #1;
        chk("rel4_vld", vld, 1);
        chk("rel4_instr", instr, 16'hF000);
        chk("rel4_ipc", ipc, 0);
        chk("rel4_mode", mode, 2'b01);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
